// File: rtl/mem_port_ctrl_pkg.sv
// Shared encodings for the memory-port controller: FSM states, request sources, widths.
package mem_port_ctrl_pkg;

  localparam int MPC_WORD_SIZE = 16;
  localparam int MPC_CNT_W     = 4;

  typedef enum logic [1:0] {
    MPC_IDLE   = 2'd0,
    MPC_ACCESS = 2'd1,
    MPC_DONE   = 2'd2
  } mpc_state_e;

  typedef enum logic {
    SRC_FETCH = 1'b0,
    SRC_DATA  = 1'b1
  } mpc_src_e;

endpackage

// File: rtl/mem_port_ctrl_arbiter.sv
// Two-way fixed-priority grant between fetch and data requests; purely combinational.
// Zero latency; the loser is not stored here, it simply keeps its request high.
module mem_port_ctrl_arbiter
  import mem_port_ctrl_pkg::*;
#(
  parameter int DATA_PRIORITY = 1
) (
  input  logic     if_req,
  input  logic     d_req,
  output logic     grant_vld,
  output mpc_src_e grant_src
);

  always_comb begin
    grant_vld = if_req | d_req;
    grant_src = SRC_FETCH;
    if (if_req && d_req) begin
      grant_src = (DATA_PRIORITY != 0) ? SRC_DATA : SRC_FETCH;
    end else if (d_req) begin
      grant_src = SRC_DATA;
    end
  end

endmodule

// File: rtl/mem_port_ctrl.sv
// Shared memory-bus controller: arbitrates fetch/data requests, holds strobes MEM_LATENCY cycles.
// Done pulses MEM_LATENCY+1 cycles after acceptance; requesters hold req until their done.
module mem_port_ctrl
  import mem_port_ctrl_pkg::*;
#(
  parameter int WORD_SIZE     = MPC_WORD_SIZE,
  parameter int MEM_LATENCY   = 1,
  parameter int DATA_PRIORITY = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 if_req,
  input  logic [WORD_SIZE-1:0] if_addr,
  output logic [WORD_SIZE-1:0] if_rdata,
  output logic                 if_done,
  input  logic                 d_req,
  input  logic                 d_we,
  input  logic [WORD_SIZE-1:0] d_addr,
  input  logic [WORD_SIZE-1:0] d_wdata,
  output logic [WORD_SIZE-1:0] d_rdata,
  output logic                 d_done,
  output logic                 busy,
  output logic                 read_m,
  output logic                 write_m,
  output logic [WORD_SIZE-1:0] address,
  inout  tri   [WORD_SIZE-1:0] data,
  output logic [WORD_SIZE-1:0] fetch_count
);

  if (MEM_LATENCY < 1 || MEM_LATENCY > 15) begin : g_latency_check
    $error("mem_port_ctrl: MEM_LATENCY must be in 1..15");
  end

  localparam logic [MPC_CNT_W-1:0] CNT_LOAD = MPC_CNT_W'(MEM_LATENCY - 1);

  mpc_state_e           state_q, state_d;
  mpc_src_e             src_q, src_d, grant_src;
  logic                 grant_vld;
  logic                 we_q, we_d;
  logic [MPC_CNT_W-1:0] cnt_q, cnt_d;
  logic                 read_m_q, read_m_d, write_m_q, write_m_d;
  logic                 if_done_q, if_done_d, d_done_q, d_done_d;
  logic [WORD_SIZE-1:0] address_q, address_d, wdata_q, wdata_d;
  logic [WORD_SIZE-1:0] if_rdata_q, if_rdata_d, d_rdata_q, d_rdata_d;
  logic [WORD_SIZE-1:0] fetch_count_q, fetch_count_d;

  // A requester sees its done during IDLE with req still high; masking it prevents a duplicate accept.
  mem_port_ctrl_arbiter #(.DATA_PRIORITY(DATA_PRIORITY)) u_arb (
    .if_req    (if_req & ~if_done_q),
    .d_req     (d_req & ~d_done_q),
    .grant_vld (grant_vld),
    .grant_src (grant_src)
  );

  always_comb begin
    state_d       = state_q;
    src_d         = src_q;
    we_d          = we_q;
    cnt_d         = cnt_q;
    read_m_d      = read_m_q;
    write_m_d     = write_m_q;
    address_d     = address_q;
    wdata_d       = wdata_q;
    if_rdata_d    = if_rdata_q;
    d_rdata_d     = d_rdata_q;
    fetch_count_d = fetch_count_q;
    if_done_d     = 1'b0;
    d_done_d      = 1'b0;
    case (state_q)
      MPC_IDLE: begin
        if (grant_vld) begin
          state_d   = MPC_ACCESS;
          src_d     = grant_src;
          we_d      = (grant_src == SRC_DATA) && d_we;
          address_d = (grant_src == SRC_DATA) ? d_addr : if_addr;
          wdata_d   = d_wdata;
          cnt_d     = CNT_LOAD;
          read_m_d  = !we_d;
          write_m_d = we_d;
        end
      end
      MPC_ACCESS: begin
        if (cnt_q == '0) begin
          state_d   = MPC_DONE;
          read_m_d  = 1'b0;
          write_m_d = 1'b0;
          if (!we_q) begin
            if (src_q == SRC_FETCH) if_rdata_d = data;
            else                    d_rdata_d  = data;
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      MPC_DONE: begin
        state_d = MPC_IDLE;
        if (src_q == SRC_FETCH) begin
          if_done_d     = 1'b1;
          fetch_count_d = fetch_count_q + 1'b1;
        end else begin
          d_done_d = 1'b1;
        end
      end
      default: state_d = MPC_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= MPC_IDLE;
      src_q         <= SRC_FETCH;
      we_q          <= 1'b0;
      cnt_q         <= '0;
      read_m_q      <= 1'b0;
      write_m_q     <= 1'b0;
      address_q     <= '0;
      wdata_q       <= '0;
      if_rdata_q    <= '0;
      d_rdata_q     <= '0;
      fetch_count_q <= '0;
      if_done_q     <= 1'b0;
      d_done_q      <= 1'b0;
    end else begin
      state_q       <= state_d;
      src_q         <= src_d;
      we_q          <= we_d;
      cnt_q         <= cnt_d;
      read_m_q      <= read_m_d;
      write_m_q     <= write_m_d;
      address_q     <= address_d;
      wdata_q       <= wdata_d;
      if_rdata_q    <= if_rdata_d;
      d_rdata_q     <= d_rdata_d;
      fetch_count_q <= fetch_count_d;
      if_done_q     <= if_done_d;
      d_done_q      <= d_done_d;
    end
  end

  assign data        = write_m_q ? wdata_q : {WORD_SIZE{1'bz}};
  assign busy        = (state_q != MPC_IDLE);
  assign read_m      = read_m_q;
  assign write_m     = write_m_q;
  assign address     = address_q;
  assign if_rdata    = if_rdata_q;
  assign d_rdata     = d_rdata_q;
  assign if_done     = if_done_q;
  assign d_done      = d_done_q;
  assign fetch_count = fetch_count_q;

endmodule

// File: tb/tb_mem_port_ctrl.sv
// Bench for mem_port_ctrl: three instances (latency 3 / data-first, latency 1 / fetch-first, 4-bit word).
`timescale 1ns/1ps
module tb_mem_port_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst;

  int checks = 0;
  int failures = 0;

  typedef struct packed {
    logic        src;
    logic [15:0] val;
  } exp_t;
  exp_t sb_a[$];
  exp_t sb_b[$];
  exp_t sb_c[$];

  function automatic logic [15:0] rom(input logic [15:0] a);
    return (a == 16'h0010) ? 16'h6C02 : (a ^ 16'hA5A5);
  endfunction

  // Instance A: MEM_LATENCY=3, data wins
  logic        a_if_req, a_d_req, a_d_we, a_if_done, a_d_done, a_busy, a_read_m, a_write_m;
  logic [15:0] a_if_addr, a_d_addr, a_d_wdata, a_if_rdata, a_d_rdata, a_address, a_fc;
  wire  [15:0] a_data;
  logic [15:0] mem_a [0:255];
  logic [255:0] wr_a;
  assign a_data = a_read_m ? (wr_a[a_address[7:0]] ? mem_a[a_address[7:0]] : rom(a_address)) : 16'hzzzz;
  always @(posedge clk) begin
    if (rst) wr_a <= '0;
    else if (a_write_m) begin
      mem_a[a_address[7:0]] <= a_data;
      wr_a[a_address[7:0]]  <= 1'b1;
    end
  end

  mem_port_ctrl #(.WORD_SIZE(16), .MEM_LATENCY(3), .DATA_PRIORITY(1)) u_a (
    .clk(clk), .reset(rst), .if_req(a_if_req), .if_addr(a_if_addr), .if_rdata(a_if_rdata),
    .if_done(a_if_done), .d_req(a_d_req), .d_we(a_d_we), .d_addr(a_d_addr), .d_wdata(a_d_wdata),
    .d_rdata(a_d_rdata), .d_done(a_d_done), .busy(a_busy), .read_m(a_read_m), .write_m(a_write_m),
    .address(a_address), .data(a_data), .fetch_count(a_fc));

  // Instance B: MEM_LATENCY=1, fetch wins
  logic        b_if_req, b_d_req, b_d_we, b_if_done, b_d_done, b_busy, b_read_m, b_write_m;
  logic [15:0] b_if_addr, b_d_addr, b_d_wdata, b_if_rdata, b_d_rdata, b_address, b_fc;
  wire  [15:0] b_data;
  assign b_data = b_read_m ? rom(b_address) : 16'hzzzz;

  mem_port_ctrl #(.WORD_SIZE(16), .MEM_LATENCY(1), .DATA_PRIORITY(0)) u_b (
    .clk(clk), .reset(rst), .if_req(b_if_req), .if_addr(b_if_addr), .if_rdata(b_if_rdata),
    .if_done(b_if_done), .d_req(b_d_req), .d_we(b_d_we), .d_addr(b_d_addr), .d_wdata(b_d_wdata),
    .d_rdata(b_d_rdata), .d_done(b_d_done), .busy(b_busy), .read_m(b_read_m), .write_m(b_write_m),
    .address(b_address), .data(b_data), .fetch_count(b_fc));

  // Instance C: 4-bit word for counter wrap
  logic       c_if_req, c_d_req, c_d_we, c_if_done, c_d_done, c_busy, c_read_m, c_write_m;
  logic [3:0] c_if_addr, c_d_addr, c_d_wdata, c_if_rdata, c_d_rdata, c_address, c_fc;
  wire  [3:0] c_data;
  assign c_data = c_read_m ? ~c_address : 4'bzzzz;

  mem_port_ctrl #(.WORD_SIZE(4), .MEM_LATENCY(1), .DATA_PRIORITY(1)) u_c (
    .clk(clk), .reset(rst), .if_req(c_if_req), .if_addr(c_if_addr), .if_rdata(c_if_rdata),
    .if_done(c_if_done), .d_req(c_d_req), .d_we(c_d_we), .d_addr(c_d_addr), .d_wdata(c_d_wdata),
    .d_rdata(c_d_rdata), .d_done(c_d_done), .busy(c_busy), .read_m(c_read_m), .write_m(c_write_m),
    .address(c_address), .data(c_data), .fetch_count(c_fc));

  task automatic test_reset();
    int seen = 0;
    rst = 1'b1;
    a_if_req = 0; a_d_req = 0; a_d_we = 0; a_if_addr = 0; a_d_addr = 0; a_d_wdata = 0;
    b_if_req = 0; b_d_req = 0; b_d_we = 0; b_if_addr = 0; b_d_addr = 0; b_d_wdata = 0;
    c_if_req = 0; c_d_req = 0; c_d_we = 0; c_if_addr = 0; c_d_addr = 0; c_d_wdata = 0;
    repeat (3) @(negedge clk);
    checks++;
    if ({a_read_m, a_write_m, a_busy, a_if_done, a_d_done} !== 5'b0) begin
      failures++; $display("FAIL reset_ctrl got=%b want=00000", {a_read_m, a_write_m, a_busy, a_if_done, a_d_done});
    end
    checks++;
    if ({a_address, a_if_rdata, a_d_rdata, a_fc} !== 64'h0) begin
      failures++; $display("FAIL reset_words got=%h want=0", {a_address, a_if_rdata, a_d_rdata, a_fc});
    end
    rst = 1'b0;
    a_if_addr = 16'h0040; a_if_req = 1'b1;
    @(negedge clk);
    checks++;
    if (!(a_read_m === 1'b1 && a_address === 16'h0040 && a_busy === 1'b1)) begin
      failures++; $display("FAIL reset_access_start read_m=%b addr=%h want 1/0040", a_read_m, a_address);
    end
    @(negedge clk);
    rst = 1'b1;
    #1;
    checks++;
    if ({a_read_m, a_write_m, a_busy} !== 3'b0) begin
      failures++; $display("FAIL reset_abort got=%b want=000", {a_read_m, a_write_m, a_busy});
    end
    a_if_req = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (a_if_done || a_d_done) seen++;
    end
    checks++;
    if (seen != 0 || a_fc !== 16'd0 || a_if_rdata !== 16'd0) begin
      failures++; $display("FAIL reset_no_done dones=%0d fc=%0d rdata=%h want 0/0/0000", seen, a_fc, a_if_rdata);
    end
  endtask

  task automatic test_fetch();
    int strobes = 0;
    int lat = -1;
    exp_t e;
    sb_b.push_back(exp_t'{src: 1'b0, val: 16'h6C02});
    b_if_addr = 16'h0010; b_if_req = 1'b1;
    for (int cyc = 1; cyc <= 10 && lat < 0; cyc++) begin
      @(negedge clk);
      if (b_read_m) begin
        strobes++;
        checks++;
        if (b_address !== 16'h0010) begin
          failures++; $display("FAIL fetch_addr got=%h want=0010", b_address);
        end
      end
      if (b_if_done) begin
        lat = cyc - 1;
        b_if_req = 1'b0;
        e = sb_b.pop_front();
        checks++;
        if (b_if_rdata !== e.val || b_fc !== 16'd1) begin
          failures++; $display("FAIL fetch_data rdata=%h fc=%0d want %h/1", b_if_rdata, b_fc, e.val);
        end
      end
    end
    checks++;
    if (lat != 2 || strobes != 1) begin
      failures++; $display("FAIL fetch_timing lat=%0d strobes=%0d want 2/1", lat, strobes);
    end
  endtask

  task automatic test_store_load();
    int strobes = 0;
    int wrong = 0;
    int lat = -1;
    exp_t e;
    @(negedge clk);
    sb_a.push_back(exp_t'{src: 1'b1, val: 16'h0000});
    a_d_we = 1'b1; a_d_addr = 16'h0020; a_d_wdata = 16'hBEEF; a_d_req = 1'b1;
    for (int cyc = 1; cyc <= 12 && lat < 0; cyc++) begin
      @(negedge clk);
      if (cyc == 1) begin
        a_d_addr = 16'h0099; a_d_wdata = 16'h1111; a_d_we = 1'b0;
      end
      if (a_read_m) wrong++;
      if (a_write_m) begin
        strobes++;
        checks++;
        if (a_address !== 16'h0020 || a_data !== 16'hBEEF) begin
          failures++; $display("FAIL store_bus addr=%h data=%h want 0020/beef", a_address, a_data);
        end
      end
      if (a_d_done) begin
        lat = cyc - 1;
        a_d_req = 1'b0;
        e = sb_a.pop_front();
        checks++;
        if (a_d_rdata !== e.val) begin
          failures++; $display("FAIL store_rdata got=%h want=%h", a_d_rdata, e.val);
        end
      end
    end
    checks++;
    if (lat != 4 || strobes != 3 || wrong != 0) begin
      failures++; $display("FAIL store_timing lat=%0d strobes=%0d reads=%0d want 4/3/0", lat, strobes, wrong);
    end
    @(negedge clk);
    sb_a.push_back(exp_t'{src: 1'b1, val: 16'hBEEF});
    strobes = 0; wrong = 0; lat = -1;
    a_d_we = 1'b0; a_d_addr = 16'h0020; a_d_req = 1'b1;
    for (int cyc = 1; cyc <= 12 && lat < 0; cyc++) begin
      @(negedge clk);
      if (a_write_m) wrong++;
      if (a_read_m) strobes++;
      if (a_d_done) begin
        lat = cyc - 1;
        a_d_req = 1'b0;
        e = sb_a.pop_front();
        checks++;
        if (a_d_rdata !== e.val || a_fc !== 16'd0) begin
          failures++; $display("FAIL load_data rdata=%h fc=%0d want %h/0", a_d_rdata, a_fc, e.val);
        end
      end
    end
    checks++;
    if (lat != 4 || strobes != 3 || wrong != 0) begin
      failures++; $display("FAIL load_timing lat=%0d strobes=%0d writes=%0d want 4/3/0", lat, strobes, wrong);
    end
  endtask

  task automatic test_priority();
    int a_if_n = 0, a_d_n = 0, b_if_n = 0, b_d_n = 0, both = 0;
    exp_t e;
    @(negedge clk);
    sb_a.push_back(exp_t'{src: 1'b1, val: 16'hA595});
    sb_a.push_back(exp_t'{src: 1'b0, val: 16'hA5A5});
    sb_b.push_back(exp_t'{src: 1'b0, val: 16'hA5A5});
    sb_b.push_back(exp_t'{src: 1'b1, val: 16'hA595});
    a_if_addr = 16'h0000; a_d_addr = 16'h0030; a_d_we = 1'b0;
    b_if_addr = 16'h0000; b_d_addr = 16'h0030; b_d_we = 1'b0;
    a_if_req = 1'b1; a_d_req = 1'b1; b_if_req = 1'b1; b_d_req = 1'b1;
    for (int cyc = 0; cyc < 30; cyc++) begin
      @(negedge clk);
      if ((a_read_m && a_write_m) || (b_read_m && b_write_m)) both++;
      if (a_if_done || a_d_done) begin
        if (a_if_done) begin a_if_n++; a_if_req = 1'b0; end
        if (a_d_done)  begin a_d_n++;  a_d_req  = 1'b0; end
        checks++;
        if (sb_a.size() == 0) begin
          failures++; $display("FAIL prio_a_extra if_done=%b d_done=%b want none", a_if_done, a_d_done);
        end else begin
          e = sb_a.pop_front();
          if (a_d_done !== e.src || (e.src ? a_d_rdata : a_if_rdata) !== e.val) begin
            failures++; $display("FAIL prio_a_order src=%b data=%h want %b/%h", a_d_done, e.src ? a_d_rdata : a_if_rdata, e.src, e.val);
          end
        end
      end
      if (b_if_done || b_d_done) begin
        if (b_if_done) begin b_if_n++; b_if_req = 1'b0; end
        if (b_d_done)  begin b_d_n++;  b_d_req  = 1'b0; end
        checks++;
        if (sb_b.size() == 0) begin
          failures++; $display("FAIL prio_b_extra if_done=%b d_done=%b want none", b_if_done, b_d_done);
        end else begin
          e = sb_b.pop_front();
          if (b_d_done !== e.src || (e.src ? b_d_rdata : b_if_rdata) !== e.val) begin
            failures++; $display("FAIL prio_b_order src=%b data=%h want %b/%h", b_d_done, e.src ? b_d_rdata : b_if_rdata, e.src, e.val);
          end
        end
      end
    end
    checks++;
    if (a_if_n != 1 || a_d_n != 1 || b_if_n != 1 || b_d_n != 1) begin
      failures++; $display("FAIL prio_counts a=%0d/%0d b=%0d/%0d want 1/1 1/1", a_if_n, a_d_n, b_if_n, b_d_n);
    end
    checks++;
    if (both != 0 || a_fc !== 16'd1 || b_fc !== 16'd2) begin
      failures++; $display("FAIL prio_state both=%0d fc_a=%0d fc_b=%0d want 0/1/2", both, a_fc, b_fc);
    end
  endtask

  task automatic test_wrap();
    logic [3:0] exp_fc = 4'd0;
    int got;
    exp_t e;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      c_if_addr = 4'(i);
      sb_c.push_back(exp_t'{src: 1'b0, val: {12'h0, ~c_if_addr}});
      c_if_req = 1'b1;
      got = 0;
      for (int cyc = 0; cyc < 10 && got == 0; cyc++) begin
        @(negedge clk);
        if (c_if_done) got = 1;
      end
      c_if_req = 1'b0;
      e = sb_c.pop_front();
      exp_fc = exp_fc + 4'd1;
      checks++;
      if (got == 0) begin
        failures++; $display("FAIL wrap_timeout fetch=%0d no if_done", i);
      end else if (c_if_rdata !== e.val[3:0] || c_fc !== exp_fc) begin
        failures++; $display("FAIL wrap_fetch%0d rdata=%h fc=%0d want %h/%0d", i, c_if_rdata, c_fc, e.val[3:0], exp_fc);
      end
    end
  endtask

  initial begin
    test_reset();
    test_fetch();
    test_store_load();
    test_priority();
    test_wrap();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
